mem_req_queue: RTL and testbench

//  In-order core-side load/store queue in front of cache_subsystem; one entry per cache request ID.

---
 rtl/mem_req_pkg.sv | 22 ++
 rtl/mem_req_perf.sv | 36 +++
 rtl/mem_req_queue.sv | 205 ++++++++++++++++++++
 tb/tb_mem_req_queue.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_pkg.sv
// mem_req_pkg: entry-state encoding, default widths and pointer sizing shared by mem_req_queue.
package mem_req_pkg;

  typedef logic [1:0] entry_state_t;

  localparam entry_state_t ST_FREE   = 2'd0;
  localparam entry_state_t ST_WAIT   = 2'd1;
  localparam entry_state_t ST_ISSUED = 2'd2;
  localparam entry_state_t ST_DONE   = 2'd3;

  localparam int DEF_ADDR_WIDTH   = 32;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_CREG_ID_BITS = 3;

  // One extra pointer bit separates full from empty when the indices match.
  localparam int PTR_WRAP_BITS = 1;

  function automatic int ptr_width(input int id_bits);
    return id_bits + PTR_WRAP_BITS;
  endfunction

endpackage

// File: rtl/mem_req_perf.sv
// mem_req_perf: free-running 32-bit counters of accepted cache requests and stalled request cycles.
module mem_req_perf
  import mem_req_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_inc_i,
  input  logic        stall_inc_i,
  output logic [31:0] req_cnt_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] req_cnt_q, req_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Next counter values; both wrap naturally at 2^32.
  always_comb begin
    req_cnt_d   = req_cnt_q + (req_inc_i ? 32'd1 : 32'd0);
    stall_cnt_d = stall_cnt_q + (stall_inc_i ? 32'd1 : 32'd0);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_cnt_q   <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      req_cnt_q   <= req_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign req_cnt_o   = req_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/mem_req_queue.sv
// mem_req_queue: in-order load/store queue, issues by entry ID and retires out-of-order responses in order.
// Define MEM_REQ_PERF_EN to add perf_req_cnt_o / perf_stall_cnt_o counters.
module mem_req_queue
  import mem_req_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CREG_ID_BITS = DEF_CREG_ID_BITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    core_valid_i,
  input  logic                    core_rw_i,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  input  logic [DATA_WIDTH-1:0]   core_data_i,
  output logic                    core_ready_o,
  output logic                    core_resp_valid_o,
  output logic                    core_resp_rw_o,
  output logic [DATA_WIDTH-1:0]   core_resp_data_o,
  input  logic                    core_resp_ack_i,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    rw_o,
  output logic                    valid_o,
  output logic [CREG_ID_BITS-1:0] id_o,
  input  logic                    cache_stall_i,
  input  logic                    cache_ready_i,
  input  logic [CREG_ID_BITS-1:0] cache_id_i,
  input  logic [DATA_WIDTH-1:0]   cache_data_i,
`ifdef MEM_REQ_PERF_EN
  output logic [31:0]             perf_req_cnt_o,
  output logic [31:0]             perf_stall_cnt_o,
`endif
  output logic                    err_o
);

  localparam int DEPTH = 1 << CREG_ID_BITS;
  localparam int PW    = ptr_width(CREG_ID_BITS);
  localparam logic [PW-1:0] DEPTH_PTR = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  entry_state_t          st_q   [DEPTH];
  entry_state_t          st_d   [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic                  rw_q   [DEPTH];
  logic                  rw_d   [DEPTH];

  logic [PW-1:0] alloc_q, alloc_d, issue_q, issue_d, retire_q, retire_d, cand_s;
  logic [CREG_ID_BITS-1:0] alloc_idx_s, issue_idx_s, retire_idx_s, cand_idx_s;
  logic [ADDR_WIDTH-1:0] oaddr_q, oaddr_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
  logic [CREG_ID_BITS-1:0] oid_q, oid_d;
  logic valid_q, valid_d, orw_q, orw_d, err_q, err_d;
  logic full_s, alloc_fire_s, accept_s, resp_valid_s, retire_fire_s;

  assign alloc_idx_s   = alloc_q[CREG_ID_BITS-1:0];
  assign issue_idx_s   = issue_q[CREG_ID_BITS-1:0];
  assign retire_idx_s  = retire_q[CREG_ID_BITS-1:0];
  assign full_s        = (alloc_q - retire_q) == DEPTH_PTR;
  assign alloc_fire_s  = core_valid_i & ~full_s;
  assign accept_s      = valid_q & ~cache_stall_i;
  assign resp_valid_s  = (st_q[retire_idx_s] == ST_DONE);
  assign retire_fire_s = core_resp_ack_i & resp_valid_s;
  // Entry presented after this edge: the next one if the current is accepted.
  assign cand_s        = accept_s ? (issue_q + PTR_ONE) : issue_q;
  assign cand_idx_s    = cand_s[CREG_ID_BITS-1:0];

  // Entry lifecycle, pointer advance and request-register reload.
  always_comb begin
    st_d     = st_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rw_d     = rw_q;
    alloc_d  = alloc_q;
    retire_d = retire_q;
    err_d    = err_q;
    valid_d  = valid_q;
    oaddr_d  = oaddr_q;
    odata_d  = odata_q;
    orw_d    = orw_q;
    oid_d    = oid_q;

    if (accept_s) begin
      st_d[issue_idx_s] = ST_ISSUED;
      issue_d           = issue_q + PTR_ONE;
    end else begin
      issue_d = issue_q;
    end

    if (cache_ready_i) begin
      if (st_q[cache_id_i] == ST_ISSUED) begin
        st_d[cache_id_i] = ST_DONE;
        if (!rw_q[cache_id_i]) begin
          data_d[cache_id_i] = cache_data_i;
        end else begin
          data_d[cache_id_i] = data_q[cache_id_i];
        end
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = err_q;
    end

    if (retire_fire_s) begin
      st_d[retire_idx_s] = ST_FREE;
      retire_d           = retire_q + PTR_ONE;
    end else begin
      retire_d = retire_q;
    end

    if (alloc_fire_s) begin
      st_d[alloc_idx_s]   = ST_WAIT;
      addr_d[alloc_idx_s] = core_addr_i;
      data_d[alloc_idx_s] = core_data_i;
      rw_d[alloc_idx_s]   = core_rw_i;
      alloc_d             = alloc_q + PTR_ONE;
    end else begin
      alloc_d = alloc_q;
    end

    // An entry allocated on this very edge is forwarded straight from the core inputs.
    if (valid_q && !accept_s) begin
      valid_d = 1'b1;
    end else if (cand_s != alloc_q) begin
      valid_d = 1'b1;
      oaddr_d = addr_q[cand_idx_s];
      odata_d = rw_q[cand_idx_s] ? data_q[cand_idx_s] : {DATA_WIDTH{1'b0}};
      orw_d   = rw_q[cand_idx_s];
      oid_d   = cand_idx_s;
    end else if (alloc_fire_s) begin
      valid_d = 1'b1;
      oaddr_d = core_addr_i;
      odata_d = core_rw_i ? core_data_i : {DATA_WIDTH{1'b0}};
      orw_d   = core_rw_i;
      oid_d   = alloc_idx_s;
    end else begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]   <= ST_FREE;
        addr_q[i] <= {ADDR_WIDTH{1'b0}};
        data_q[i] <= {DATA_WIDTH{1'b0}};
        rw_q[i]   <= 1'b0;
      end
      alloc_q  <= {PW{1'b0}};
      issue_q  <= {PW{1'b0}};
      retire_q <= {PW{1'b0}};
      valid_q  <= 1'b0;
      oaddr_q  <= {ADDR_WIDTH{1'b0}};
      odata_q  <= {DATA_WIDTH{1'b0}};
      orw_q    <= 1'b0;
      oid_q    <= {CREG_ID_BITS{1'b0}};
      err_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rw_q     <= rw_d;
      alloc_q  <= alloc_d;
      issue_q  <= issue_d;
      retire_q <= retire_d;
      valid_q  <= valid_d;
      oaddr_q  <= oaddr_d;
      odata_q  <= odata_d;
      orw_q    <= orw_d;
      oid_q    <= oid_d;
      err_q    <= err_d;
    end
  end

  assign core_ready_o      = ~full_s;
  assign core_resp_valid_o = resp_valid_s;
  assign core_resp_rw_o    = resp_valid_s & rw_q[retire_idx_s];
  assign core_resp_data_o  = (resp_valid_s & ~rw_q[retire_idx_s]) ? data_q[retire_idx_s]
                                                                   : {DATA_WIDTH{1'b0}};
  assign addr_o  = oaddr_q;
  assign data_o  = odata_q;
  assign rw_o    = orw_q;
  assign valid_o = valid_q;
  assign id_o    = oid_q;
  assign err_o   = err_q;

`ifdef MEM_REQ_PERF_EN
  mem_req_perf u_perf (
    .clk         (clk),
    .reset       (reset),
    .req_inc_i   (accept_s),
    .stall_inc_i (valid_q & cache_stall_i),
    .req_cnt_o   (perf_req_cnt_o),
    .stall_cnt_o (perf_stall_cnt_o)
  );
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_req_queue.sv
// tb_mem_req_queue: randomized and directed stimulus against a transaction-list model of mem_req_queue.
module tb_mem_req_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_valid_i, core_rw_i, core_resp_ack_i;
  logic [31:0] core_addr_i, core_data_i, cache_data_i;
  logic        cache_stall_i, cache_ready_i;
  logic [2:0]  cache_id_i;
  logic        core_ready_o, core_resp_valid_o, core_resp_rw_o, rw_o, valid_o, err_o;
  logic [31:0] core_resp_data_o, addr_o, data_o;
  logic [2:0]  id_o;
`ifdef MEM_REQ_PERF_EN
  logic [31:0] perf_req_cnt_o, perf_stall_cnt_o;
`endif

  always #5 clk = ~clk;

  mem_req_queue dut (
    .clk(clk), .reset(reset),
    .core_valid_i(core_valid_i), .core_rw_i(core_rw_i), .core_addr_i(core_addr_i),
    .core_data_i(core_data_i), .core_ready_o(core_ready_o),
    .core_resp_valid_o(core_resp_valid_o), .core_resp_rw_o(core_resp_rw_o),
    .core_resp_data_o(core_resp_data_o), .core_resp_ack_i(core_resp_ack_i),
    .addr_o(addr_o), .data_o(data_o), .rw_o(rw_o), .valid_o(valid_o), .id_o(id_o),
    .cache_stall_i(cache_stall_i), .cache_ready_i(cache_ready_i),
    .cache_id_i(cache_id_i), .cache_data_i(cache_data_i),
`ifdef MEM_REQ_PERF_EN
    .perf_req_cnt_o(perf_req_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o),
`endif
    .err_o(err_o)
  );

  typedef struct {
    int          id;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    bit          issued;
    bit          done;
  } txn_t;

  txn_t        q[$];
  int          alloc_cnt = 0;
  bit          m_err = 1'b0;
  logic [31:0] m_req = 32'd0;
  logic [31:0] m_stall = 32'd0;
  int          vec_cnt = 0;
  int          miscompares = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int first_unissued();
    foreach (q[i]) if (!q[i].issued) return i;
    return -1;
  endfunction

  // Applies the queue's rules to the inputs present at a rising edge.
  function automatic void model_update();
    int fu;
    bit do_ret;
    bit hit;
    int pre_size;
    if (!reset) begin
      q.delete();
      alloc_cnt = 0;
      m_err     = 1'b0;
      m_req     = 32'd0;
      m_stall   = 32'd0;
      return;
    end
    fu       = first_unissued();
    do_ret   = core_resp_ack_i && q.size() > 0 && q[0].done;
    pre_size = q.size();
    if (cache_ready_i) begin
      hit = 1'b0;
      foreach (q[i]) begin
        if (q[i].id == int'(cache_id_i) && q[i].issued && !q[i].done) begin
          hit       = 1'b1;
          q[i].done = 1'b1;
          if (!q[i].rw) q[i].rdata = cache_data_i;
        end
      end
      if (!hit) m_err = 1'b1;
    end
    if (fu >= 0) begin
      if (!cache_stall_i) begin
        q[fu].issued = 1'b1;
        m_req++;
      end else begin
        m_stall++;
      end
    end
    if (do_ret) void'(q.pop_front());
    if (core_valid_i && pre_size < DEPTH) begin
      q.push_back('{alloc_cnt % DEPTH, core_rw_i, core_addr_i, core_data_i, 32'd0, 1'b0, 1'b0});
      alloc_cnt++;
    end
  endfunction

  task automatic check_outputs();
    int fu;
    fu = first_unissued();
    check_val("core_ready", 64'(core_ready_o), 64'(q.size() < DEPTH));
    check_val("valid_o", 64'(valid_o), 64'(fu >= 0));
    if (fu >= 0) begin
      check_val("id_o", 64'(id_o), 64'(q[fu].id));
      check_val("addr_o", 64'(addr_o), 64'(q[fu].addr));
      check_val("rw_o", 64'(rw_o), 64'(q[fu].rw));
      if (q[fu].rw) check_val("data_o", 64'(data_o), 64'(q[fu].data));
    end
    check_val("resp_valid", 64'(core_resp_valid_o), 64'(q.size() > 0 && q[0].done));
    if (q.size() > 0 && q[0].done) begin
      check_val("resp_rw", 64'(core_resp_rw_o), 64'(q[0].rw));
      check_val("resp_data", 64'(core_resp_data_o), 64'(q[0].rw ? 32'd0 : q[0].rdata));
    end
    check_val("err_o", 64'(err_o), 64'(m_err));
`ifdef MEM_REQ_PERF_EN
    check_val("perf_req", 64'(perf_req_cnt_o), 64'(m_req));
    check_val("perf_stall", 64'(perf_stall_cnt_o), 64'(m_stall));
`endif
  endtask

  task automatic step(input logic cv, input logic crw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic stall, input logic cr, input logic [2:0] cid,
                      input logic [31:0] cdat, input logic ack);
    core_valid_i    = cv;
    core_rw_i       = crw;
    core_addr_i     = ca;
    core_data_i     = cd;
    cache_stall_i   = stall;
    cache_ready_i   = cr;
    cache_id_i      = cid;
    cache_data_i    = cdat;
    core_resp_ack_i = ack;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, ack);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2, 1'b0);
    check_val("rst_ready", 64'(core_ready_o), 64'd1);
    check_val("rst_valid", 64'(valid_o), 64'd0);
    check_val("rst_resp_valid", 64'(core_resp_valid_o), 64'd0);
    check_val("rst_err", 64'(err_o), 64'd0);
    check_val("rst_addr", 64'(addr_o), 64'd0);
    check_val("rst_data", 64'(data_o), 64'd0);
    check_val("rst_id", 64'(id_o), 64'd0);
    reset = 1'b1;
  endtask

  task automatic rand_cycle(input int pv);
    int       iss[$];
    logic     cr;
    logic [2:0] cid;
    foreach (q[i]) if (q[i].issued && !q[i].done) iss.push_back(q[i].id);
    cr  = 1'b0;
    cid = 3'd0;
    if (iss.size() > 0 && $urandom_range(0, 1) == 1) begin
      cr  = 1'b1;
      cid = 3'(iss[$urandom_range(0, iss.size() - 1)]);
    end
    step(1'(int'($urandom_range(0, 99)) < pv), 1'($urandom_range(0, 1)), $urandom, $urandom,
         1'($urandom_range(0, 3) == 0), cr, cid, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 1000) begin
      rand_cycle(0);
      guard++;
    end
    check_val("drain_valid_o", 64'(valid_o), 64'd0);
    check_val("drain_resp_valid", 64'(core_resp_valid_o), 64'd0);
    check_val("drain_ready", 64'(core_ready_o), 64'd1);
  endtask

  initial begin
    reset = 1'b0;
    core_valid_i = 1'b0; core_rw_i = 1'b0; core_addr_i = 32'd0; core_data_i = 32'd0;
    cache_stall_i = 1'b0; cache_ready_i = 1'b0; cache_id_i = 3'd0; cache_data_i = 32'd0;
    core_resp_ack_i = 1'b0;
    @(negedge clk);
    do_reset();

    // Single load, response three cycles after allocation.
    step(1'b1, 1'b0, 32'h100, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    check_val("t1_valid_o", 64'(valid_o), 64'd1);
    idle(2, 1'b0);
    check_val("t1_valid_dropped", 64'(valid_o), 64'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 3'd0, 32'hDEADBEEF, 1'b0);
    check_val("t1_resp_valid", 64'(core_resp_valid_o), 64'd1);
    check_val("t1_resp_data", 64'(core_resp_data_o), 64'hDEADBEEF);
    check_val("t1_resp_rw", 64'(core_resp_rw_o), 64'd0);
    idle(1, 1'b1);

    // Fill all eight entries; the ninth waits for the first retirement.
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b0, 32'(i * 4), 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    check_val("t2_full", 64'(core_ready_o), 64'd0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 32'h900, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 32'h900, 32'd0, 1'b0, 1'b1, 3'd0, 32'h1234, 1'b0);
    check_val("t2_still_full", 64'(core_ready_o), 64'd0);
    step(1'b1, 1'b0, 32'h900, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
    check_val("t2_ready_after_ack", 64'(core_ready_o), 64'd1);
    step(1'b1, 1'b0, 32'h900, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    check_val("t2_ninth_id", 64'(id_o), 64'd0);
    drain();

    // Out-of-order responses 2,0,1 retire in program order.
    do_reset();
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 32'(32'h200 + i), 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
    idle(1, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 3'd2, 32'hA2, 1'b1);
    check_val("t3_no_resp_yet", 64'(core_resp_valid_o), 64'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 3'd0, 32'hA0, 1'b1);
    check_val("t3_head_data", 64'(core_resp_data_o), 64'hA0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 3'd1, 32'hA1, 1'b1);
    idle(3, 1'b1);

    // Five stalled cycles keep the request stable.
    do_reset();
    step(1'b1, 1'b1, 32'h400, 32'h55AA, 1'b1, 1'b0, 3'd0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0, 1'b0);
      check_val("t4_addr_stable", 64'(addr_o), 64'h400);
    end
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    check_val("t4_accepted", 64'(valid_o), 64'd0);
`ifdef MEM_REQ_PERF_EN
    check_val("t4_perf_stall", 64'(perf_stall_cnt_o), 64'd5);
`endif
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 3'd0, 32'd0, 1'b1);
    idle(2, 1'b1);

    // Response to a free entry raises a sticky error.
    do_reset();
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 3'd5, 32'hBAD, 1'b0);
    check_val("t5_err", 64'(err_o), 64'd1);
    idle(3, 1'b1);
    check_val("t5_err_sticky", 64'(err_o), 64'd1);
    check_val("t5_ready", 64'(core_ready_o), 64'd1);

    // Reset with four issued entries, then twenty requests across a pointer wrap.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 32'(32'h600 + i), 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    idle(1, 1'b0);
    do_reset();
    begin
      int guard;
      guard = 0;
      while (alloc_cnt < 20 && guard < 500) begin
        rand_cycle(70);
        guard++;
      end
    end
    drain();
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 3'd3, 32'd0, 1'b0);
    check_val("t6_late_err", 64'(err_o), 64'd1);

    // Long randomized run with varying request pressure.
    do_reset();
    for (int i = 0; i < 1500; i++) rand_cycle((i / 300) % 2 == 0 ? 80 : 30);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
